// File: rtl/cp0_irq_pending_pkg.sv
// ============================================================================
//  Module      : cp0_irq_pending_pkg
//  Description : Shared CP0 constants for the interrupt-pending vector and the
//                mtc0 write-target decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_irq_pending_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // CP0 register numbers seen on the mtc0 write port
   localparam logic [4:0] COUNT_ADDR   = 5'd9;
   localparam logic [4:0] COMPARE_ADDR = 5'd11;
   localparam logic [4:0] CAUSE_ADDR   = 5'd13;

   // Bit positions inside the pending vector
   localparam int IP_TIMER = 7;
   localparam int IP_IO_HI = 6;
   localparam int IP_IO_LO = 2;
   localparam int IP_SW_HI = 1;

   // Compare comes out of reset all-ones; sliced down to COUNT_W by the user
   localparam logic [63:0] COMPARE_RESET = {64{1'b1}};

   typedef enum logic [1:0] {
      WR_NONE    = 2'd0,
      WR_COUNT   = 2'd1,
      WR_COMPARE = 2'd2,
      WR_CAUSE   = 2'd3
   } mtc0_target_e;

   function automatic mtc0_target_e decode_target(input logic we, input logic [4:0] addr);
      mtc0_target_e t;
      t = WR_NONE;
      if (we == ENABLE) begin
         case (addr)
            COUNT_ADDR:   t = WR_COUNT;
            COMPARE_ADDR: t = WR_COMPARE;
            CAUSE_ADDR:   t = WR_CAUSE;
            default:      t = WR_NONE;
         endcase
      end
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_irq_pending_if.sv
// ============================================================================
//  Module      : cp0_irq_pending_if
//  Description : mtc0 write port, external IO lines and pending/timer outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_irq_pending_if #(
   parameter int COUNT_W = 32
);
   logic               mtc0_we;
   logic [4:0]         mtc0_addr;
   logic [COUNT_W-1:0] mtc0_data;
   logic [4:0]         io_int_in;
   logic [7:0]         ip;
   logic [COUNT_W-1:0] count_o;
   logic [COUNT_W-1:0] compare_o;

   modport master (
      output mtc0_we, mtc0_addr, mtc0_data, io_int_in,
      input  ip, count_o, compare_o
   );

   modport slave (
      input  mtc0_we, mtc0_addr, mtc0_data, io_int_in,
      output ip, count_o, compare_o
   );
endinterface

`default_nettype wire

// File: rtl/cp0_sync_ff.sv
// ============================================================================
//  Module      : cp0_sync_ff
//  Description : N-stage synchronous-reset flop chain for asynchronous levels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] i_d,
   output logic      [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cp0_irq_pending.sv
// ============================================================================
//  Module      : cp0_irq_pending
//  Description : Source of Cause.IP[7:0]: Count/Compare timer, synchronised IO
//                interrupt lines and software-interrupt bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_irq_pending
   import cp0_irq_pending_pkg::*;
#(
   parameter int COUNT_W        = 32,
   parameter int IO_SYNC_STAGES = 2,
   parameter int COUNT_DIV      = 2
) (
   input wire logic          clk,
   input wire logic          rst,
   cp0_irq_pending_if.slave  bus
);

   mtc0_target_e       w_target;
   logic               w_inc;
   logic               w_match;
   logic [4:0]         w_io_sync;
   logic [7:0]         w_ip;

   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] r_compare;
   logic               r_timer_ip;
   logic [1:0]         r_sw_ip;

   assign w_target = decode_target(bus.mtc0_we, bus.mtc0_addr);
   assign w_match  = (r_count == r_compare);

   generate
      if (COUNT_DIV == 1) begin : g_div1
         assign w_inc = ENABLE;
      end else begin : g_div2
         logic r_tick;
         // Count writes leave the phase alone so the increment cadence is stable
         always_ff @(posedge clk) begin
            if (rst) begin
               r_tick <= DISABLE;
            end else begin
               r_tick <= ~r_tick;
            end
         end
         assign w_inc = r_tick;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_target == WR_COUNT) begin
         r_count <= bus.mtc0_data;
      end else if (w_inc) begin
         r_count <= r_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_compare <= COMPARE_RESET[COUNT_W-1:0];
      end else if (w_target == WR_COMPARE) begin
         r_compare <= bus.mtc0_data;
      end
   end

   // Sticky timer request; a Compare write acknowledges it and wins over a match
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer_ip <= DISABLE;
      end else if (w_target == WR_COMPARE) begin
         r_timer_ip <= DISABLE;
      end else if (w_match) begin
         r_timer_ip <= ENABLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_ip <= 2'b00;
      end else if (w_target == WR_CAUSE) begin
         r_sw_ip <= bus.mtc0_data[9:8];
      end
   end

   cp0_sync_ff #(
      .WIDTH  (5),
      .STAGES (IO_SYNC_STAGES)
   ) u_io_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.io_int_in),
      .o_q (w_io_sync)
   );

   always_comb begin
      w_ip                     = 8'h00;
      w_ip[IP_TIMER]           = r_timer_ip;
      w_ip[IP_IO_HI:IP_IO_LO]  = w_io_sync;
      w_ip[IP_SW_HI:0]         = r_sw_ip;
   end

   assign bus.ip        = w_ip;
   assign bus.count_o   = r_count;
   assign bus.compare_o = r_compare;

endmodule

`default_nettype wire

// File: doc/cp0_irq_pending.md
Name: cp0_irq_pending

Overview:
- Upstream source of the CP0 interrupt-pending vector (Cause.IP[7:0]). Feeds the interrupt-request stage, which masks IP with IM/IE and priority-encodes it.
- Holds the Count/Compare timer (IP[7]), the synchroniser for the external IO interrupt lines (IP[6:2]) and the software-interrupt bits (IP[1:0]).
- Register writes arrive on the mtc0 write port. Count and Compare are exported for mfc0 reads.

Parameters:
- COUNT_W, 32, width of the Count and Compare registers.
- IO_SYNC_STAGES, 2, flop stages on each external IO interrupt line (minimum 2).
- COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles (legal values 1 or 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mtc0_we  in  1  CP0 register write strobe.
- mtc0_addr  in  5  CP0 register number: 9=Count, 11=Compare, 13=Cause.
- mtc0_data  in  COUNT_W  write data.
- io_int_in  in  5  asynchronous, level-sensitive external interrupt lines.
- ip  out  8  pending vector {timer, io[4:0], sw[1:0]}, registered.
- count_o  out  COUNT_W  current Count.
- compare_o  out  COUNT_W  current Compare.

Behaviour:
- Reset values (all at the edge where rst=1):
  - count=0, compare=all-ones, prescale tick=0, timer_ip=0, sw_ip=0, all sync flops=0, so ip=8'h00.
  - rst has priority over every other input, including mid-operation writes.
- Prescaler:
  - COUNT_DIV=2: tick toggles every cycle; count increments on edges where tick=1. First increment is the 2nd edge after reset deasserts.
  - COUNT_DIV=1: count increments every edge.
- Count:
  - Wraps from all-ones to 0 with no flag.
  - Write to addr 9: count<=mtc0_data, overriding that cycle's increment. Tick is unaffected.
- Compare:
  - Write to addr 11: compare<=mtc0_data, and timer_ip clears at the same edge. The clear beats a simultaneous set.
- Timer pending:
  - At each edge, timer_ip is set if the registered count==compare and no Compare write is occurring. Once set it is sticky until a Compare write or reset.
  - Latency: timer_ip rises one edge after the edge at which count becomes equal to compare.
  - A same-cycle Count and Compare write to equal values sets timer_ip at the following edge.
- IO pending:
  - Each io_int_in bit passes through an IO_SYNC_STAGES-deep flop chain. ip[6:2] is the last stage, with no extra latching.
  - A change on an input appears on ip exactly IO_SYNC_STAGES edges later.
  - Level-sensitive: no ack path, and the bit clears when the source drops.
- Software pending:
  - Write to addr 13: sw_ip<=mtc0_data[9:8]. Other Cause bits are ignored here.
  - A Cause write never alters ip[7:2].
- Other writes: mtc0_we with any other address has no effect on this block.
- Outputs: ip={timer_ip, io_sync[4:0], sw_ip}. count_o and compare_o come directly from the registers. No combinational path from inputs to outputs.

Decomposition:
- Shared header (with the existing ENABLE/DISABLE constants):
  - CP0 register numbers COUNT_ADDR=9, COMPARE_ADDR=11, CAUSE_ADDR=13.
  - IP bit positions IP_TIMER=7, IP_IO_HI=6, IP_IO_LO=2, IP_SW_HI=1.
  - Compare reset value.
- One sub-module: cp0_sync_ff, a parameterised N-stage synchronous-reset synchroniser, instantiated once with width 5.
- Timer, prescaler and software bits stay in the top module.

Test Plan:
1. Reset and free-run: assert rst 3 cycles, then release. Required: ip=8'h00, compare_o=32'hFFFFFFFF, and count_o=5 after 10 edges (COUNT_DIV=2).
2. Timer match and clear:
   - Write Compare=10 with count=0. Count reaches 10 at edge 20, ip[7]=1 at edge 21, and it holds past count=11.
   - Write Compare=100. ip[7]=0 at the write edge.
3. Simultaneous writes and wrap:
   - Write Count=0x20 and Compare=0x20 in consecutive cycles. ip[7]=1 one edge after both equal.
   - Separately, Count=32'hFFFFFFFF wraps to 0 on its next increment.
4. IO synchroniser: drive io_int_in=5'b00100. ip[4] rises exactly 2 edges later, ip elsewhere unchanged. Drop the line and ip[4] falls 2 edges later.
5. Software bits:
   - Cause write 0x300 gives ip[1:0]=2'b11 next edge; Cause write 0x100 gives 2'b01.
   - With ip[7]=1 and ip[4]=1, neither Cause write changes them.
   - Write to addr 12 changes nothing.
6. Reset mid-operation: with ip=8'h93 and count running, pulse rst 1 cycle. At that edge ip=0, count=0, compare=all-ones. A Compare write in the same cycle is discarded.
